// File: rtl/cdc_pkg.sv
// Shared types for the pulse event queue: FSM state encoding and channel index width helper.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Index width never drops below one bit so single-channel builds still get a port.
  function automatic int CH_IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: the search starts at the channel after ptr and picks the first requester.
module rr_arbiter
  import cdc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = CH_IDX_W(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_CH);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/cdc_pulse_event_queue.sv
// Per-channel event counters feeding a single handshake pulse synchronizer, one event per
// round-robin grant, paced by the downstream busy flag.
module cdc_pulse_event_queue
  import cdc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 3
) (
  input  logic                        s_clk,
  input  logic                        s_rst,
  input  logic [NUM_CH-1:0]           s_pulse_in,
  input  logic                        s_busy,
  output logic                        s_pulse_out,
  output logic [CH_IDX_W(NUM_CH)-1:0] s_ch_out,
  output logic [NUM_CH-1:0]           s_pending,
  input  logic [NUM_CH-1:0]           s_ovf_clr,
  output logic [NUM_CH-1:0]           s_overflow
);

  localparam int               IDX_W   = CH_IDX_W(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state;
  logic [NUM_CH-1:0]  pulse_q;
  logic [CNT_W-1:0]   cnt      [NUM_CH];
  logic [CNT_W-1:0]   cnt_next [NUM_CH];
  logic [NUM_CH-1:0]  req;
  logic [NUM_CH-1:0]  grant;
  logic [NUM_CH-1:0]  dec;
  logic [NUM_CH-1:0]  ovf_set;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic               issue;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      req[i] = (cnt[i] != '0);
    end
  end

  assign s_pending = req;
  assign issue     = (state == IDLE) && (|req) && !s_busy;
  assign dec       = issue ? grant : '0;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gnt_idx)
  );

  // A simultaneous increment and issue cancel out; an increment at saturation is lost and flagged.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_next[i] = cnt[i];
      ovf_set[i]  = 1'b0;
      case ({pulse_q[i], dec[i]})
        2'b10: begin
          if (cnt[i] == CNT_MAX) ovf_set[i] = 1'b1;
          else                   cnt_next[i] = cnt[i] + 1'b1;
        end
        2'b01:   cnt_next[i] = cnt[i] - 1'b1;
        default: cnt_next[i] = cnt[i];
      endcase
    end
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      pulse_q    <= '0;
      s_overflow <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      pulse_q    <= s_pulse_in;
      s_overflow <= ovf_set | (s_overflow & ~s_ovf_clr);
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= cnt_next[i];
    end
  end

  // Pointer resets to the last channel so channel 0 wins the first search.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state       <= IDLE;
      s_pulse_out <= 1'b0;
      s_ch_out    <= '0;
      ptr         <= IDX_W'(NUM_CH - 1);
    end else begin
      case (state)
        IDLE: begin
          s_pulse_out <= 1'b0;
          if (issue) begin
            state       <= ISSUE;
            s_pulse_out <= 1'b1;
            s_ch_out    <= gnt_idx;
            ptr         <= gnt_idx;
          end
        end
        ISSUE: begin
          state       <= WAIT;
          s_pulse_out <= 1'b0;
        end
        WAIT: begin
          s_pulse_out <= 1'b0;
          if (!s_busy) state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          s_pulse_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_pulse_event_queue.sv
// Directed and random stimulus for the pulse event queue, checked every cycle against a
// queue-level model built from event-count and pacing rules.
module tb_cdc_pulse_event_queue;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 2;
  localparam int MAXC   = 3;

  logic       s_clk = 1'b0;
  logic       s_rst;
  logic [3:0] s_pulse_in;
  logic       s_busy;
  logic       s_pulse_out;
  logic [1:0] s_ch_out;
  logic [3:0] s_pending;
  logic [3:0] s_ovf_clr;
  logic [3:0] s_overflow;

  int errors = 0;
  int checks = 0;

  int       m_cnt [NUM_CH];
  bit [3:0] m_ovf;
  bit [3:0] m_seen;
  int       m_last;
  bit       m_free;
  int       m_age;
  bit       m_pulse;
  int       m_ch;

  int pulses_seen;
  int cycle_no = 0;
  int pulse_times[$];
  int pulse_chs[$];

  always #5 s_clk = ~s_clk;

  cdc_pulse_event_queue #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .s_clk       (s_clk),
    .s_rst       (s_rst),
    .s_pulse_in  (s_pulse_in),
    .s_busy      (s_busy),
    .s_pulse_out (s_pulse_out),
    .s_ch_out    (s_ch_out),
    .s_pending   (s_pending),
    .s_ovf_clr   (s_ovf_clr),
    .s_overflow  (s_overflow)
  );

  // Model: an event seen at an edge is counted one edge later; one issue per free slot,
  // a slot reopens two edges after an issue once busy is seen low.
  task automatic model_edge();
    int  g;
    bit  inc, set;
    if (s_rst) begin
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
      m_ovf = '0; m_seen = '0; m_last = NUM_CH - 1; m_free = 1'b1;
      m_age = 0; m_pulse = 1'b0; m_ch = 0;
      return;
    end
    g = -1;
    if (m_free && !s_busy) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        if (g < 0 && m_cnt[(m_last + k) % NUM_CH] > 0) g = (m_last + k) % NUM_CH;
      end
    end
    m_pulse = (g >= 0);
    if (g >= 0) begin
      m_ch = g; m_last = g; m_free = 1'b0; m_age = 0;
    end else if (!m_free) begin
      m_age++;
      if (m_age >= 2 && !s_busy) m_free = 1'b1;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      inc = m_seen[i];
      set = 1'b0;
      if (inc && g != i) begin
        if (m_cnt[i] == MAXC) set = 1'b1;
        else                  m_cnt[i]++;
      end else if (!inc && g == i) begin
        m_cnt[i]--;
      end
      m_ovf[i] = set | (m_ovf[i] & ~s_ovf_clr[i]);
    end
    m_seen = s_pulse_in;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    logic [3:0] exp_pend;
    for (int i = 0; i < NUM_CH; i++) exp_pend[i] = (m_cnt[i] > 0);
    chk("pulse_out", 32'(s_pulse_out), 32'(m_pulse));
    chk("ch_out",    32'(s_ch_out),    32'(m_ch));
    chk("pending",   32'(s_pending),   32'(exp_pend));
    chk("overflow",  32'(s_overflow),  32'(m_ovf));
  endtask

  task automatic apply_stimulus(input bit rst, input bit busy, input logic [3:0] pin,
                                input logic [3:0] clr);
    s_rst = rst; s_busy = busy; s_pulse_in = pin; s_ovf_clr = clr;
    @(posedge s_clk);
    model_edge();
    #1;
    cycle_no++;
    if (s_pulse_out === 1'b1) begin
      pulses_seen++;
      pulse_times.push_back(cycle_no);
      pulse_chs.push_back(int'(s_ch_out));
    end
    check_output();
  endtask

  task automatic clear_log();
    pulses_seen = 0;
    pulse_times.delete();
    pulse_chs.delete();
  endtask

  initial begin
    bit found;
    s_rst = 1'b1; s_busy = 1'b0; s_pulse_in = '0; s_ovf_clr = '0;

    // Reset with pulses present: all of them must vanish.
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 4'($urandom), 4'h0);
    chk("reset_pending", 32'(s_pending), 32'h0);

    // Single event and its two-edge latency.
    for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 4'h0, 4'h0);
    clear_log();
    apply_stimulus(0, 0, 4'b0100, 4'h0);
    apply_stimulus(0, 0, 4'h0, 4'h0);
    chk("lat_n1_pulse", 32'(s_pulse_out), 32'h0);
    apply_stimulus(0, 0, 4'h0, 4'h0);
    chk("lat_n2_pulse", 32'(s_pulse_out), 32'h1);
    chk("lat_n2_ch", 32'(s_ch_out), 32'h2);
    for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 4'h0, 4'h0);
    chk("single_count", 32'(pulses_seen), 32'h1);

    // Burst while busy, then drained at minimum spacing.
    clear_log();
    for (int i = 0; i < 20; i++)
      apply_stimulus(0, 1, (i == 2 || i == 5 || i == 8) ? 4'b0010 : 4'h0, 4'h0);
    chk("burst_none_while_busy", 32'(pulses_seen), 32'h0);
    for (int i = 0; i < 12; i++) apply_stimulus(0, 0, 4'h0, 4'h0);
    chk("burst_count", 32'(pulses_seen), 32'h3);
    if (pulse_times.size() == 3) begin
      chk("burst_gap1", 32'(pulse_times[1] - pulse_times[0]), 32'h3);
      chk("burst_gap2", 32'(pulse_times[2] - pulse_times[1]), 32'h3);
    end
    chk("burst_ovf1", 32'(s_overflow[1]), 32'h0);

    // Saturation and sticky overflow on channel 0.
    clear_log();
    for (int i = 0; i < 5; i++) apply_stimulus(0, 1, 4'b0001, 4'h0);
    for (int i = 0; i < 2; i++) apply_stimulus(0, 1, 4'h0, 4'h0);
    chk("ovf_set", 32'(s_overflow[0]), 32'h1);
    apply_stimulus(0, 1, 4'h0, 4'b0001);
    chk("ovf_clr", 32'(s_overflow[0]), 32'h0);
    for (int i = 0; i < 12; i++) apply_stimulus(0, 0, 4'h0, 4'h0);
    chk("sat_drain_count", 32'(pulses_seen), 32'h3);

    // Fairness from a fresh pointer with two events per channel.
    apply_stimulus(1, 0, 4'h0, 4'h0);
    clear_log();
    apply_stimulus(0, 1, 4'hF, 4'h0);
    apply_stimulus(0, 1, 4'hF, 4'h0);
    apply_stimulus(0, 1, 4'h0, 4'h0);
    apply_stimulus(0, 1, 4'h0, 4'h0);
    for (int i = 0; i < 26; i++) apply_stimulus(0, 0, 4'h0, 4'h0);
    chk("rr_count", 32'(pulses_seen), 32'h8);
    if (pulse_chs.size() == 8)
      for (int i = 0; i < 8; i++) chk("rr_order", 32'(pulse_chs[i]), 32'(i % 4));

    // Event on channel 3 lands on the same edge as its own issue.
    apply_stimulus(1, 0, 4'h0, 4'h0);
    clear_log();
    apply_stimulus(0, 1, 4'b1000, 4'h0);
    apply_stimulus(0, 1, 4'h0, 4'h0);
    apply_stimulus(0, 1, 4'h0, 4'h0);
    apply_stimulus(0, 1, 4'b1000, 4'h0);
    apply_stimulus(0, 0, 4'h0, 4'h0);
    chk("simul_issue", 32'(s_pulse_out), 32'h1);
    chk("simul_pend3", 32'(s_pending[3]), 32'h1);
    for (int i = 0; i < 10; i++) apply_stimulus(0, 0, 4'h0, 4'h0);
    chk("simul_count", 32'(pulses_seen), 32'h2);

    // Reset landing in an issue cycle with work still queued.
    apply_stimulus(0, 1, 4'b0110, 4'h0);
    apply_stimulus(0, 1, 4'b0110, 4'h0);
    apply_stimulus(0, 1, 4'h0, 4'h0);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      apply_stimulus(0, 0, 4'h0, 4'h0);
      if (s_pulse_out === 1'b1) found = 1'b1;
    end
    chk("rst_mid_issue_seen", 32'(found), 32'h1);
    apply_stimulus(1, 0, 4'hF, 4'h0);
    chk("rst_mid_pulse", 32'(s_pulse_out), 32'h0);
    chk("rst_mid_pending", 32'(s_pending), 32'h0);
    clear_log();
    for (int i = 0; i < 10; i++) apply_stimulus(0, 0, 4'h0, 4'h0);
    chk("rst_mid_quiet", 32'(pulses_seen), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 99) == 0,
                     $urandom_range(0, 2) == 0,
                     4'($urandom) & 4'($urandom),
                     ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdc_pulse_event_queue.md
CDC_PULSE_EVENT_QUEUE -- requirements
Module: cdc_pulse_event_queue

Parameters
REQ-001 The block SHALL have parameter NUM_CH, default 4, number of independent source event channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 3, width of the per-channel pending-event counter (1..8).

Interface
REQ-003 The block SHALL have port s_clk, input, 1, source-domain clock.
REQ-004 The block SHALL have port s_rst, input, 1, reset, synchronous to s_clk and active-high.
REQ-005 The block SHALL have port s_pulse_in, input, NUM_CH, per-channel event pulses, sampled on every s_clk edge.
REQ-006 The block SHALL have port s_busy, input, 1, busy flag from the downstream handshake pulse synchronizer, asserted no later than the cycle after s_pulse_out.
REQ-007 The block SHALL have port s_pulse_out, output, 1, single-cycle event pulse to the downstream synchronizer.
REQ-008 The block SHALL have port s_ch_out, output, $clog2(NUM_CH) (min 1), channel index of the last issued pulse, held stable until the next issue.
REQ-009 The block SHALL have port s_pending, output, NUM_CH, per-channel flag, high when that channel's counter is nonzero.
REQ-010 The block SHALL have port s_ovf_clr, input, NUM_CH, per-channel overflow clear.
REQ-011 The block SHALL have port s_overflow, output, NUM_CH, per-channel sticky overflow flag.

Function
REQ-012 Per channel: a CNT_W-bit counter SHALL increment on s_pulse_in[i] and decrement on an issue for channel i; when both occur in one cycle, the counter SHALL be unchanged.
REQ-013 The counter SHALL saturate at 2^CNT_W-1; a pulse at saturation without a same-cycle decrement SHALL be dropped and SHALL set s_overflow[i].
REQ-014 s_overflow[i] SHALL clear on s_ovf_clr[i] unless a new overflow occurs in the same cycle, in which case set wins.
REQ-015 FSM states SHALL be IDLE, ISSUE and WAIT; IDLE->ISSUE when any counter is nonzero and s_busy=0; ISSUE->WAIT unconditionally; WAIT->IDLE when s_busy=0.
REQ-016 s_pulse_out SHALL be registered and high exactly during ISSUE, for one cycle, which guarantees it never asserts while s_busy=1 or in the cycle after a prior pulse.
REQ-017 Grant SHALL be round-robin: search starts at the channel after the last granted one and takes the first nonzero counter; the pointer updates only on issue.
REQ-018 Latency: s_pulse_in[i] sampled at edge N with an empty queue, state IDLE and s_busy=0 SHALL produce s_pulse_out high after edge N+2.
REQ-019 The decrement SHALL occur on the ISSUE transition edge, so s_pending reflects the post-issue count in the ISSUE cycle.
REQ-020 Minimum spacing between s_pulse_out assertions SHALL be 3 cycles, reached when s_busy stays 0.

Reset
REQ-021 On s_rst: counters=0, s_overflow=0, state=IDLE, s_pulse_out=0, s_ch_out=0, s_pending=0, and the RR pointer SHALL be set so that channel 0 has highest priority.
REQ-022 s_pulse_in asserted during reset SHALL be discarded; reset mid-ISSUE SHALL force s_pulse_out=0 on the next edge.

Structure
REQ-023 The shared package cdc_pkg SHALL hold the FSM state enum (IDLE/ISSUE/WAIT) and the CH_IDX_W width function.
REQ-024 The round-robin grant SHALL be a sub-module rr_arbiter (request vector, pointer in; one-hot grant, index out).

Verification
REQ-025 Single event: NUM_CH=4, s_busy=0, pulse ch2 at cycle 10 -> s_pulse_out=1 at cycle 12 with s_ch_out=2, exactly one pulse.
REQ-026 Burst during busy: s_busy=1 for 20 cycles, 3 pulses on ch1 -> after busy drops, 3 issues at 3-cycle spacing, s_overflow[1]=0.
REQ-027 Overflow: CNT_W=2, s_busy=1, 5 pulses on ch0 -> counter=3, s_overflow[0]=1; then s_ovf_clr[0] -> s_overflow[0]=0.
REQ-028 Fairness: all 4 channels hold pending counts of 2, s_busy=0 -> s_ch_out sequence 0,1,2,3,0,1,2,3.
REQ-029 Simultaneous: ch3 pulses in its own ISSUE cycle with count=1 -> count stays 1, one further issue follows.
REQ-030 Reset mid-operation: s_rst asserted in the ISSUE cycle with pending counts -> all outputs 0 next cycle, no later pulse without new input.
